// File: rtl/key_unroll.sv
// S-AES key unroller: takes the final round key and emits key2, key1, key0 by inverting key expansion.
// Optional KEY_CHECK_EN adds a CHECK state that re-expands key0 and compares it with the stored key2.
module key_unroll (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [15:0] key_in,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [15:0] out_key,
    output logic [1:0]  out_idx,
    output logic        out_last,
    output logic        chk_valid,
    output logic        key_ok
);

    localparam int unsigned KW = 16;
    localparam int unsigned BW = 8;
    localparam int unsigned IW = 2;

    localparam logic [BW-1:0] RC_K1 = 8'h30;
    localparam logic [BW-1:0] RC_K0 = 8'h80;

`ifdef KEY_CHECK_EN
    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_EMIT  = 2'd1,
        S_CHECK = 2'd2
    } state_t;
`else
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_EMIT = 2'd1
    } state_t;
`endif

    function automatic logic [3:0] sbox(input logic [3:0] n);
        logic [3:0] r;
        case (n)
            4'h0: r = 4'h9;
            4'h1: r = 4'h4;
            4'h2: r = 4'hA;
            4'h3: r = 4'hB;
            4'h4: r = 4'hD;
            4'h5: r = 4'h1;
            4'h6: r = 4'h8;
            4'h7: r = 4'h5;
            4'h8: r = 4'h6;
            4'h9: r = 4'h2;
            4'hA: r = 4'h0;
            4'hB: r = 4'h3;
            4'hC: r = 4'hC;
            4'hD: r = 4'hE;
            4'hE: r = 4'hF;
            default: r = 4'h7;
        endcase
        return r;
    endfunction

    // SubNib(RotNib(w)) ^ rc
    function automatic logic [BW-1:0] g_fn(input logic [BW-1:0] w, input logic [BW-1:0] rc);
        return {sbox(w[3:0]), sbox(w[7:4])} ^ rc;
    endfunction

    function automatic logic [KW-1:0] back_step(input logic [KW-1:0] k, input logic [BW-1:0] rc);
        logic [BW-1:0] b_n;
        b_n = k[15:8] ^ k[7:0];
        return {k[15:8] ^ g_fn(b_n, rc), b_n};
    endfunction

    state_t          state_q;
    logic [KW-1:0]   key_q;
    logic [IW-1:0]   idx_q;
    logic            out_valid_q;
    logic            out_last_q;
    logic            in_ready_q;
    logic [KW-1:0]   step_d;
    logic [BW-1:0]   rc_d;

    assign rc_d   = (idx_q == IW'(2)) ? RC_K1 : RC_K0;
    assign step_d = back_step(key_q, rc_d);

`ifdef KEY_CHECK_EN
    logic [KW-1:0] key2_q;
    logic          chk_valid_q;
    logic          key_ok_q;

    function automatic logic [KW-1:0] fwd_expand(input logic [KW-1:0] k0);
        logic [BW-1:0] w2, w3, w4;
        w2 = k0[15:8] ^ g_fn(k0[7:0], RC_K0);
        w3 = w2 ^ k0[7:0];
        w4 = w2 ^ g_fn(w3, RC_K1);
        return {w4, w4 ^ w3};
    endfunction
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            key_q       <= '0;
            idx_q       <= '0;
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
            in_ready_q  <= 1'b1;
`ifdef KEY_CHECK_EN
            key2_q      <= '0;
            chk_valid_q <= 1'b0;
            key_ok_q    <= 1'b0;
`endif
        end else begin
`ifdef KEY_CHECK_EN
            chk_valid_q <= 1'b0;
`endif
            case (state_q)
                S_IDLE: begin
                    if (in_valid && in_ready_q) begin
                        key_q       <= key_in;
`ifdef KEY_CHECK_EN
                        key2_q      <= key_in;
`endif
                        idx_q       <= IW'(2);
                        out_valid_q <= 1'b1;
                        out_last_q  <= 1'b0;
                        in_ready_q  <= 1'b0;
                        state_q     <= S_EMIT;
                    end
                end
                S_EMIT: begin
                    if (out_ready) begin
                        if (idx_q != IW'(0)) begin
                            key_q      <= step_d;
                            idx_q      <= idx_q - IW'(1);
                            out_last_q <= (idx_q == IW'(1));
                        end else begin
                            out_valid_q <= 1'b0;
                            out_last_q  <= 1'b0;
`ifdef KEY_CHECK_EN
                            state_q     <= S_CHECK;
`else
                            in_ready_q  <= 1'b1;
                            state_q     <= S_IDLE;
`endif
                        end
                    end
                end
`ifdef KEY_CHECK_EN
                // key_q holds the recovered key0 here
                S_CHECK: begin
                    chk_valid_q <= 1'b1;
                    key_ok_q    <= (fwd_expand(key_q) == key2_q);
                    in_ready_q  <= 1'b1;
                    state_q     <= S_IDLE;
                end
`endif
                default: begin
                    out_valid_q <= 1'b0;
                    out_last_q  <= 1'b0;
                    in_ready_q  <= 1'b1;
                    state_q     <= S_IDLE;
                end
            endcase
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign out_key   = key_q;
    assign out_idx   = idx_q;
    assign out_last  = out_last_q;

`ifdef KEY_CHECK_EN
    assign chk_valid = chk_valid_q;
    assign key_ok    = key_ok_q;
`else
    assign chk_valid = 1'b0;
    assign key_ok    = 1'b0;
`endif

endmodule

// File: doc/key_unroll.md
KEY_UNROLL -- requirements
Module: key_unroll

Interface
Parameters: none.
REQ-001 The port list SHALL be:
- clk  in  1  single clock, rising edge.
- rst  in  1  synchronous reset, active-high.
- in_valid  in  1  key_in is valid.
- in_ready  out  1  block can accept a final round key.
- key_in  in  16  final S-AES round key (key2 = {w4,w5}).
- out_valid  out  1  out_key is valid.
- out_ready  in  1  consumer accepts out_key.
- out_key  out  16  round key, decryption order.
- out_idx  out  2  round index of out_key: 2, then 1, then 0.
- out_last  out  1  high with the idx-0 beat.
- chk_valid  out  1  one-cycle pulse when key_ok is valid.
- key_ok  out  1  forward re-expansion matched key_in.
REQ-002 The block SHALL use one clock domain with synchronous active-high reset rst; clk and rst are the names as given.

Function
REQ-003 The block SHALL recover key1 and key0 from key2 by inverting S-AES key expansion, one step per emitted beat.
REQ-004 With {a,b} as the current key, the backward step SHALL be:
- b' = a ^ b
- a' = a ^ RC ^ SubNib(RotNib(b'))
- the result is {a',b'}.
- RC SHALL be 8'h30 for key2->key1 and 8'h80 for key1->key0.
REQ-005 RotNib SHALL swap the two nibbles of a byte.
REQ-006 SubNib SHALL map each nibble through the S-AES S-box 9,4,A,B,D,1,8,5,6,2,0,3,C,E,F,7 (input 0..F).
REQ-007 The state machine SHALL have states IDLE, EMIT and CHECK; CHECK exists only with KEY_CHECK_EN.
REQ-008 In IDLE, in_ready SHALL be 1 and out_valid SHALL be 0; in all other states in_ready SHALL be 0.
REQ-009 When in_valid && in_ready at edge t, the block SHALL:
- register key_in,
- enter EMIT,
- assert out_valid from cycle t+1 with out_key = key_in and out_idx = 2.
REQ-010 While out_valid && !out_ready, out_key, out_idx and out_last SHALL hold stable.
REQ-011 On each accepted beat (out_valid && out_ready) with out_idx > 0:
- the next cycle SHALL present the backward-step result,
- out_idx SHALL decrement,
- out_valid SHALL stay 1 (no bubble).
REQ-012 out_last SHALL be 1 exactly when out_idx = 0 and out_valid = 1.
REQ-013 On acceptance of the idx-0 beat, the block SHALL go to CHECK (macro defined) or IDLE (macro undefined).
- With no back-pressure the minimum input-to-input interval is 4 cycles without the macro and 5 with it.
REQ-014 in_valid asserted outside IDLE SHALL be ignored; no input is queued.
REQ-015 All arithmetic SHALL be 8-bit XOR; no carries; no width extension.

Reset
REQ-016 On rst = 1 at a clock edge, the block SHALL:
- enter IDLE,
- set in_ready = 1,
- set out_valid, out_last, chk_valid and key_ok = 0,
- set out_key = 16'h0000 and out_idx = 2'd0.
REQ-017 Reset asserted mid-sequence SHALL abort the sequence; no further beats are emitted and the stored key is discarded.

Configuration
REQ-018 Macro KEY_CHECK_EN defined:
- CHECK SHALL last one cycle.
- In CHECK the block SHALL forward-expand the recovered key0 and compare the result with the stored key2.
- The next cycle SHALL pulse chk_valid = 1 with key_ok = (match), then return to IDLE.
- key_ok SHALL hold its value until the next check or reset.
REQ-019 Macro KEY_CHECK_EN undefined:
- No CHECK state SHALL exist.
- chk_valid and key_ok SHALL be constant 0.

Verification
REQ-020 key_in = 16'h87AF, out_ready = 1 -> beats (87AF,2), (DD28,1), (4AF5,0,last); with macro, chk_valid pulse with key_ok = 1.
REQ-021 key_in = 16'h0D14 -> beats 0D14, 1919, 0000; with macro, key_ok = 1.
REQ-022 key_in = 16'h87AF, out_ready low for 3 cycles on each beat -> outputs stable while stalled, same 3 values in order, no duplicates.
REQ-023 rst pulsed after the idx-1 beat -> next cycle out_valid = 0, in_ready = 1; a new key_in = 16'h0D14 then yields the full 0D14/1919/0000 sequence.
REQ-024 in_valid held high with a second key during EMIT -> second key not accepted until IDLE; in_ready = 0 throughout EMIT/CHECK.
